demo_scene_sequencer: RTL and testbench

//  Autonomous show controller for the VGA/PWM demo datapath. Steps through 4 scenes,

---
 rtl/demo_seq_pkg.sv | 22 ++
 rtl/demo_scene_sequencer_if.sv | 39 +++
 rtl/demo_scene_sequencer_btn_debounce.sv | 49 ++++
 rtl/demo_scene_sequencer.sv | 166 ++++++++++++++++
 tb/tb_demo_scene_sequencer.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/demo_seq_pkg.sv
// Shared types and constants for the demo show sequencer.
// Scene order, audio mapping and the fade range live here so the top and bench agree.
package demo_seq_pkg;

  typedef enum logic [1:0] {
    PLAY     = 2'd0,
    FADE_OUT = 2'd1,
    SWITCH   = 2'd2,
    FADE_IN  = 2'd3
  } seq_state_t;

  localparam int NUM_SCENES = 4;
  localparam logic [1:0] FADE_MAX = 2'd3;

  // Element i is the tune played with scene i.
  localparam logic [NUM_SCENES-1:0][1:0] AUDIO_MAP = {2'd3, 2'd2, 2'd1, 2'd0};

  function automatic logic [1:0] next_scene(input logic [1:0] idx);
    return (idx == 2'(NUM_SCENES - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

endpackage

// File: rtl/demo_scene_sequencer_if.sv
// Control/status bundle between the scene sequencer and the VGA/PWM wrapper.
// The sequencer takes the master side; the wrapper (or a bench) takes the slave side.
interface demo_scene_sequencer_if;

  logic       frame_start;
  logic       next_btn;
  logic       manual_en;
  logic [1:0] manual_state;
  logic [1:0] manual_audio;
  logic [1:0] vga_state;
  logic [1:0] audio_select;
  logic [1:0] fade_level;
  logic       scene_change;

  modport master (
    input  frame_start,
    input  next_btn,
    input  manual_en,
    input  manual_state,
    input  manual_audio,
    output vga_state,
    output audio_select,
    output fade_level,
    output scene_change
  );

  modport slave (
    output frame_start,
    output next_btn,
    output manual_en,
    output manual_state,
    output manual_audio,
    input  vga_state,
    input  audio_select,
    input  fade_level,
    input  scene_change
  );

endinterface

// File: rtl/demo_scene_sequencer_btn_debounce.sv
// Push-button conditioner: synchroniser chain, stability counter and a one-cycle
// pulse on each debounced press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int SYNC_STAGES     = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic rise_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic                   stable_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   rise_reg;
  logic                   synced;

  assign synced     = sync_reg[SYNC_STAGES-1];
  assign rise_pulse = rise_reg;

  // The stable level flips only after DEBOUNCE_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_reg   <= '0;
      stable_reg <= 1'b0;
      cnt_reg    <= '0;
      rise_reg   <= 1'b0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], btn_raw};
      rise_reg <= 1'b0;
      if (synced != stable_reg) begin
        if (cnt_reg == CNT_LAST) begin
          stable_reg <= synced;
          cnt_reg    <= '0;
          rise_reg   <= synced;
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end else begin
        cnt_reg <= '0;
      end
    end
  end

endmodule

// File: rtl/demo_scene_sequencer.sv
// Autonomous show controller: plays four scenes in turn with fades between them,
// honours a debounced skip button and a frame-synchronous manual override.
module demo_scene_sequencer
  import demo_seq_pkg::*;
#(
  parameter int FRAMES_PER_SCENE = 600,
  parameter int FADE_STEP_FRAMES = 4,
  parameter int DEBOUNCE_CYCLES  = 250000
) (
  input logic clk,
  input logic rst,
  demo_scene_sequencer_if.master bus
);

  localparam int FCNT_W = (FRAMES_PER_SCENE > 1) ? $clog2(FRAMES_PER_SCENE) : 1;
  localparam int STEP_W = (FADE_STEP_FRAMES > 1) ? $clog2(FADE_STEP_FRAMES) : 1;
  localparam logic [FCNT_W-1:0] FRAME_LAST = FCNT_W'(FRAMES_PER_SCENE - 1);
  localparam logic [STEP_W-1:0] STEP_LAST  = STEP_W'(FADE_STEP_FRAMES - 1);

  seq_state_t        state_reg,        state_next;
  logic [1:0]        scene_idx_reg,    scene_idx_next;
  logic [FCNT_W-1:0] frame_cnt_reg,    frame_cnt_next;
  logic [STEP_W-1:0] step_cnt_reg,     step_cnt_next;
  logic [1:0]        fade_reg,         fade_next;
  logic [1:0]        vga_reg,          vga_next;
  logic [1:0]        audio_reg,        audio_next;
  logic              scene_change_reg, scene_change_next;
  logic              skip_pend_reg,    skip_pend_next;
  logic              manual_active_reg, manual_active_next;

  logic       btn_rise;
  logic       skip_now;
  logic       step_tick;
  logic [1:0] scene_adv;

  btn_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn (
    .clk       (clk),
    .rst       (rst),
    .btn_raw   (bus.next_btn),
    .rise_pulse(btn_rise)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= PLAY;
      scene_idx_reg     <= 2'd0;
      frame_cnt_reg     <= '0;
      step_cnt_reg      <= '0;
      fade_reg          <= FADE_MAX;
      vga_reg           <= 2'd0;
      audio_reg         <= AUDIO_MAP[0];
      scene_change_reg  <= 1'b0;
      skip_pend_reg     <= 1'b0;
      manual_active_reg <= 1'b0;
    end else begin
      state_reg         <= state_next;
      scene_idx_reg     <= scene_idx_next;
      frame_cnt_reg     <= frame_cnt_next;
      step_cnt_reg      <= step_cnt_next;
      fade_reg          <= fade_next;
      vga_reg           <= vga_next;
      audio_reg         <= audio_next;
      scene_change_reg  <= scene_change_next;
      skip_pend_reg     <= skip_pend_next;
      manual_active_reg <= manual_active_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    scene_idx_next     = scene_idx_reg;
    frame_cnt_next     = frame_cnt_reg;
    step_cnt_next      = step_cnt_reg;
    fade_next          = fade_reg;
    vga_next           = vga_reg;
    audio_next         = audio_reg;
    scene_change_next  = 1'b0;
    skip_pend_next     = skip_pend_reg;
    manual_active_next = manual_active_reg;

    // A press coinciding with frame_start is honoured by that same frame_start.
    skip_now  = skip_pend_reg | btn_rise;
    step_tick = (step_cnt_reg == STEP_LAST);
    scene_adv = next_scene(scene_idx_reg);

    // Presses only latch while auto-playing; during fades they are dropped.
    if (btn_rise && (state_reg == PLAY) && !manual_active_reg) begin
      skip_pend_next = 1'b1;
    end

    if (bus.frame_start) begin
      if (bus.manual_en) begin
        manual_active_next = 1'b1;
        vga_next           = bus.manual_state;
        audio_next         = bus.manual_audio;
        fade_next          = FADE_MAX;
        state_next         = PLAY;
        frame_cnt_next     = '0;
        step_cnt_next      = '0;
        skip_pend_next     = 1'b0;
        scene_change_next  = (bus.manual_state != vga_reg);
      end else if (manual_active_reg) begin
        // Auto mode picks up from whatever scene manual mode left on screen.
        manual_active_next = 1'b0;
        scene_idx_next     = vga_reg;
        state_next         = PLAY;
        frame_cnt_next     = '0;
        step_cnt_next      = '0;
        skip_pend_next     = 1'b0;
      end else begin
        case (state_reg)
          PLAY: begin
            if ((frame_cnt_reg == FRAME_LAST) || skip_now) begin
              state_next     = FADE_OUT;
              frame_cnt_next = '0;
              step_cnt_next  = '0;
              skip_pend_next = 1'b0;
            end else begin
              frame_cnt_next = frame_cnt_reg + 1'b1;
            end
          end
          FADE_OUT: begin
            if (step_tick) begin
              step_cnt_next = '0;
              fade_next     = fade_reg - 2'd1;
              if (fade_reg == 2'd1) begin
                state_next = SWITCH;
              end
            end else begin
              step_cnt_next = step_cnt_reg + 1'b1;
            end
          end
          SWITCH: begin
            scene_idx_next    = scene_adv;
            vga_next          = scene_adv;
            audio_next        = AUDIO_MAP[scene_adv];
            scene_change_next = 1'b1;
            step_cnt_next     = '0;
            state_next        = FADE_IN;
          end
          FADE_IN: begin
            if (step_tick) begin
              step_cnt_next = '0;
              fade_next     = fade_reg + 2'd1;
              if (fade_reg == FADE_MAX - 2'd1) begin
                state_next     = PLAY;
                frame_cnt_next = '0;
              end
            end else begin
              step_cnt_next = step_cnt_reg + 1'b1;
            end
          end
          default: state_next = PLAY;
        endcase
      end
    end
  end

  assign bus.vga_state    = vga_reg;
  assign bus.audio_select = audio_reg;
  assign bus.fade_level   = fade_reg;
  assign bus.scene_change = scene_change_reg;

endmodule

// File: tb/tb_demo_scene_sequencer.sv
// Randomised scoreboard bench for demo_scene_sequencer using a frame-schedule reference model.
module tb_demo_scene_sequencer;

  localparam int F         = 3;
  localparam int S         = 1;
  localparam int DEB       = 4;
  localparam int FRAME_LEN = 40;

  typedef struct packed {
    logic [1:0] vga;
    logic [1:0] audio;
    logic [1:0] fade;
    logic       sc;
  } exp_t;

  logic clk;
  logic rst;
  bit   mon_en;
  bit   fs_seen;
  int   n_tests;
  int   n_fail;

  exp_t exp_q[$];
  exp_t mon_e;
  logic [1:0] cur_vga, cur_audio, cur_fade;

  // Reference model: k counts frame_starts since the current scene started playing.
  int m_k, m_scene, m_vga, m_audio, m_fade;
  bit m_skip, m_manual;

  demo_scene_sequencer_if bus ();

  demo_scene_sequencer #(
    .FRAMES_PER_SCENE(F),
    .FADE_STEP_FRAMES(S),
    .DEBOUNCE_CYCLES (DEB)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) fs_seen <= bus.frame_start;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per frame_start, otherwise demands steady outputs.
  always @(negedge clk) begin
    if (!mon_en) begin
      cur_vga   = 2'd0;
      cur_audio = 2'd0;
      cur_fade  = 2'd3;
    end else if (fs_seen) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL scoreboard_empty: got frame output, expected nothing queued");
      end else begin
        mon_e = exp_q.pop_front();
        check("frame_vga",   int'(bus.vga_state),    int'(mon_e.vga));
        check("frame_audio", int'(bus.audio_select), int'(mon_e.audio));
        check("frame_fade",  int'(bus.fade_level),   int'(mon_e.fade));
        check("frame_scene_change", int'(bus.scene_change), int'(mon_e.sc));
        cur_vga   = mon_e.vga;
        cur_audio = mon_e.audio;
        cur_fade  = mon_e.fade;
      end
    end else begin
      check("hold_outputs",
            int'({bus.vga_state, bus.audio_select, bus.fade_level, bus.scene_change}),
            int'({cur_vga, cur_audio, cur_fade, 1'b0}));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int fade_at(input int k);
    if (k < F)              return 3;
    else if (k <= F + 3*S)  return 3 - (k - F) / S;
    else                    return (k - F - 3*S - 1) / S;
  endfunction

  task automatic model_frame();
    exp_t e;
    bit   sc;
    sc = 1'b0;
    if (bus.manual_en) begin
      sc       = (m_vga != int'(bus.manual_state));
      m_vga    = int'(bus.manual_state);
      m_audio  = int'(bus.manual_audio);
      m_fade   = 3;
      m_k      = 0;
      m_skip   = 1'b0;
      m_manual = 1'b1;
    end else if (m_manual) begin
      m_manual = 1'b0;
      m_scene  = m_vga;
      m_k      = 0;
      m_skip   = 1'b0;
      m_fade   = 3;
    end else begin
      if (m_k < F) begin
        if (m_k == F - 1 || m_skip) begin
          m_k    = F;
          m_skip = 1'b0;
        end else begin
          m_k++;
        end
      end else begin
        m_k++;
        if (m_k == F + 3*S + 1) begin
          m_scene = (m_scene + 1) % 4;
          m_vga   = m_scene;
          m_audio = m_scene;
          sc      = 1'b1;
        end
        if (m_k == F + 6*S + 1) m_k = 0;
      end
      m_fade = fade_at(m_k);
    end
    e.vga   = 2'(m_vga);
    e.audio = 2'(m_audio);
    e.fade  = 2'(m_fade);
    e.sc    = sc;
    exp_q.push_back(e);
  endtask

  // One frame of FRAME_LEN idle cycles with an optional press, then a frame_start.
  task automatic run_frame(input int press_len);
    for (int c = 0; c < FRAME_LEN; c++) begin
      if (c == 3) bus.next_btn = (press_len > 0);
      if (c == 3 + press_len) bus.next_btn = 1'b0;
      tick();
    end
    if (press_len >= DEB && !m_manual && m_k < F) m_skip = 1'b1;
    model_frame();
    bus.frame_start = 1'b1;
    tick();
    bus.frame_start = 1'b0;
  endtask

  task automatic model_reset();
    m_k = 0; m_scene = 0; m_vga = 0; m_audio = 0; m_fade = 3;
    m_skip = 1'b0; m_manual = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    mon_en  = 1'b0;
    rst     = 1'b1;
    bus.frame_start  = 1'b0;
    bus.next_btn     = 1'b0;
    bus.manual_en    = 1'b0;
    bus.manual_state = 2'd0;
    bus.manual_audio = 2'd0;
    model_reset();

    repeat (3) tick();
    check("reset_vga",   int'(bus.vga_state),    0);
    check("reset_audio", int'(bus.audio_select), 0);
    check("reset_fade",  int'(bus.fade_level),   3);
    check("reset_scene_change", int'(bus.scene_change), 0);
    rst    = 1'b0;
    mon_en = 1'b1;

    // First scene cycle, then three more to see the 3 -> 0 wrap.
    repeat (10) run_frame(0);
    check("first_switch_vga", int'(bus.vga_state), 1);
    repeat (30) run_frame(0);
    check("wrap_vga", int'(bus.vga_state), 0);

    // Short press ignored, long press at PLAY frame 0 skips.
    run_frame(3);
    for (int i = 0; i < 20 && m_k != 0; i++) run_frame(0);
    run_frame(6);
    repeat (2) run_frame(0);

    // Press during fade-in is dropped.
    for (int i = 0; i < 20 && m_k != F + 3*S + 2; i++) run_frame(0);
    run_frame(6);
    repeat (6) run_frame(0);

    // Manual override mid-frame, then release back to auto.
    bus.manual_en    = 1'b1;
    bus.manual_state = 2'd2;
    bus.manual_audio = 2'd3;
    run_frame(0);
    check("manual_vga",   int'(bus.vga_state),    2);
    check("manual_audio", int'(bus.audio_select), 3);
    run_frame(6);
    bus.manual_en = 1'b0;
    repeat (9) run_frame(0);
    check("resume_next_vga", int'(bus.vga_state), 3);
    repeat (4) run_frame(0);

    // Randomised mix of presses and manual episodes.
    for (int i = 0; i < 200; i++) begin
      int r;
      int plen;
      r = int'($urandom_range(0, 9));
      if (r == 0) begin
        bus.manual_en    = ~bus.manual_en;
        bus.manual_state = 2'($urandom_range(0, 3));
        bus.manual_audio = 2'($urandom_range(0, 3));
      end else if (r == 1 && bus.manual_en) begin
        bus.manual_state = 2'($urandom_range(0, 3));
        bus.manual_audio = 2'($urandom_range(0, 3));
      end
      plen = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 8)) : 0;
      run_frame(plen);
    end

    // Asynchronous reset while fading out at fade_level 1.
    bus.manual_en = 1'b0;
    for (int i = 0; i < 100 && !(m_k == F + 2*S && !m_manual); i++) run_frame(0);
    if (!(m_k == F + 2*S && !m_manual)) begin
      n_tests++;
      n_fail++;
      $display("FAIL reach_fade1: got k=%0d, expected k=%0d", m_k, F + 2*S);
    end
    repeat (5) tick();
    check("pre_reset_fade", int'(bus.fade_level), 1);
    mon_en = 1'b0;
    #1;
    rst = 1'b1;
    #1;
    check("async_reset_vga",   int'(bus.vga_state),    0);
    check("async_reset_audio", int'(bus.audio_select), 0);
    check("async_reset_fade",  int'(bus.fade_level),   3);
    check("async_reset_scene_change", int'(bus.scene_change), 0);
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
    model_reset();
    tick();
    mon_en = 1'b1;
    repeat (12) run_frame(0);

    repeat (3) tick();
    check("queue_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
